// File: rtl/nes_input_pkg.sv
// Shared constants and the SNES-to-NES button mapping for the joypad register block.
package nes_input_pkg;

    localparam int unsigned SNES_B      = 0;
    localparam int unsigned SNES_Y      = 1;
    localparam int unsigned SNES_SELECT = 2;
    localparam int unsigned SNES_START  = 3;
    localparam int unsigned SNES_UP     = 4;
    localparam int unsigned SNES_DOWN   = 5;
    localparam int unsigned SNES_LEFT   = 6;
    localparam int unsigned SNES_RIGHT  = 7;
    localparam int unsigned SNES_A      = 8;
    localparam int unsigned SNES_X      = 9;

    localparam int unsigned NES_A      = 0;
    localparam int unsigned NES_B      = 1;
    localparam int unsigned NES_SELECT = 2;
    localparam int unsigned NES_START  = 3;
    localparam int unsigned NES_UP     = 4;
    localparam int unsigned NES_DOWN   = 5;
    localparam int unsigned NES_LEFT   = 6;
    localparam int unsigned NES_RIGHT  = 7;

    localparam logic [15:0] JOY1_ADDR = 16'h4016;
    localparam logic [15:0] JOY2_ADDR = 16'h4017;
    localparam logic [7:0]  OPEN_BUS  = 8'h40;

    typedef logic [7:0] nes_btn_t;

    // L and R are never passed in; X/Y only matter while turbo is high.
    function automatic nes_btn_t map_snes(input logic [9:0] snes, input logic turbo);
        nes_btn_t nes;
        nes[NES_A]      = snes[SNES_A] | (snes[SNES_X] & turbo);
        nes[NES_B]      = snes[SNES_B] | (snes[SNES_Y] & turbo);
        nes[NES_SELECT] = snes[SNES_SELECT];
        nes[NES_START]  = snes[SNES_START];
        nes[NES_UP]     = snes[SNES_UP];
        nes[NES_DOWN]   = snes[SNES_DOWN];
        nes[NES_LEFT]   = snes[SNES_LEFT];
        nes[NES_RIGHT]  = snes[SNES_RIGHT];
        return nes;
    endfunction

endpackage

// File: rtl/nes_shift_port.sv
// One NES joypad serial port: 8-bit parallel load, shift right with 1s filling from the top.
module nes_shift_port
    import nes_input_pkg::*;
(
    input  logic     clk_i,
    input  logic     rst_ni,
    input  logic     load_i,
    input  logic     shift_i,
    input  nes_btn_t data_i,
    output logic     q0_o
);

    nes_btn_t sr_q, sr_d;

    // Load has priority so a strobe write in the same cycle as a read reloads.
    always_comb begin
        sr_d = sr_q;
        if (load_i) begin
            sr_d = data_i;
        end else if (shift_i) begin
            sr_d = {1'b1, sr_q[7:1]};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sr_q <= 8'hFF;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign q0_o = sr_q[0];

endmodule

// File: rtl/nes_joypad_regs.sv
// NES $4016/$4017 joypad registers fed from SNES button vectors.
// Optional turbo on X/Y is enabled by defining JOYPAD_TURBO_EN.
module nes_joypad_regs
    import nes_input_pkg::*;
#(
    parameter int unsigned TURBO_DIV = 833333
) (
    input  logic        CLOCK,
    input  logic        RESET_N,
    input  logic [11:0] BUTTONS1,
    input  logic [11:0] BUTTONS2,
    input  logic [15:0] CPU_ADDR,
    input  logic        CPU_WR,
    input  logic        CPU_RD,
    input  logic [7:0]  CPU_WDATA,
    output logic [7:0]  CPU_RDATA,
    output logic        CPU_RVALID
);

    logic [9:0] btn1_q, btn2_q;
    logic       strobe_q, strobe_d;
    logic [7:0] rdata_q, rdata_d;
    logic       rvalid_q, rvalid_d;
    logic       turbo_phase;
    nes_btn_t   map1, map2;
    logic       wr_joy1, rd_joy1, rd_joy2;
    logic       load, q0_1, q0_2, rd_bit;

`ifdef JOYPAD_TURBO_EN
    localparam int unsigned CntW = (TURBO_DIV > 1) ? $clog2(TURBO_DIV) : 1;

    logic [CntW-1:0] turbo_cnt_q, turbo_cnt_d;
    logic            turbo_phase_q, turbo_phase_d;

    always_comb begin
        turbo_cnt_d   = turbo_cnt_q + 1'b1;
        turbo_phase_d = turbo_phase_q;
        if (turbo_cnt_q == CntW'(TURBO_DIV - 1)) begin
            turbo_cnt_d   = '0;
            turbo_phase_d = ~turbo_phase_q;
        end
    end

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            turbo_cnt_q   <= '0;
            turbo_phase_q <= 1'b0;
        end else begin
            turbo_cnt_q   <= turbo_cnt_d;
            turbo_phase_q <= turbo_phase_d;
        end
    end

    assign turbo_phase = turbo_phase_q;
`else
    logic unused_turbo_div;
    assign unused_turbo_div = ^TURBO_DIV;
    assign turbo_phase      = 1'b0;
`endif

    logic unused_inputs;
    assign unused_inputs = ^{BUTTONS1[11:10], BUTTONS2[11:10], CPU_WDATA[7:1]};

    assign map1 = map_snes(btn1_q, turbo_phase);
    assign map2 = map_snes(btn2_q, turbo_phase);

    assign wr_joy1 = CPU_WR && (CPU_ADDR == JOY1_ADDR);
    assign rd_joy1 = CPU_RD && (CPU_ADDR == JOY1_ADDR);
    assign rd_joy2 = CPU_RD && (CPU_ADDR == JOY2_ADDR);

    // A strobe-setting write reloads on the same edge, beating any concurrent shift.
    assign load = strobe_q | (wr_joy1 & CPU_WDATA[0]);

    always_comb begin
        strobe_d = strobe_q;
        if (wr_joy1) begin
            strobe_d = CPU_WDATA[0];
        end
    end

    always_comb begin
        rd_bit   = 1'b0;
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;
        if (rd_joy1) begin
            rd_bit = strobe_q ? map1[NES_A] : q0_1;
        end else if (rd_joy2) begin
            rd_bit = strobe_q ? map2[NES_A] : q0_2;
        end
        if (rd_joy1 || rd_joy2) begin
            rdata_d  = OPEN_BUS | {7'b0, rd_bit};
            rvalid_d = 1'b1;
        end
    end

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            btn1_q   <= '0;
            btn2_q   <= '0;
            strobe_q <= 1'b0;
            rdata_q  <= 8'h00;
            rvalid_q <= 1'b0;
        end else begin
            btn1_q   <= BUTTONS1[9:0];
            btn2_q   <= BUTTONS2[9:0];
            strobe_q <= strobe_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
        end
    end

    nes_shift_port u_port1 (
        .clk_i  (CLOCK),
        .rst_ni (RESET_N),
        .load_i (load),
        .shift_i(rd_joy1 & ~strobe_q),
        .data_i (map1),
        .q0_o   (q0_1)
    );

    nes_shift_port u_port2 (
        .clk_i  (CLOCK),
        .rst_ni (RESET_N),
        .load_i (load),
        .shift_i(rd_joy2 & ~strobe_q),
        .data_i (map2),
        .q0_o   (q0_2)
    );

    assign CPU_RDATA  = rdata_q;
    assign CPU_RVALID = rvalid_q;

endmodule

// File: tb/tb_nes_joypad_regs.sv
// Scoreboard bench for nes_joypad_regs: stimulus pushes expected read data, a monitor pops on CPU_RVALID.
module tb_nes_joypad_regs;

    localparam int unsigned TurboDiv = 4;

    logic        CLOCK = 1'b0;
    logic        RESET_N;
    logic [11:0] BUTTONS1, BUTTONS2;
    logic [15:0] CPU_ADDR;
    logic        CPU_WR, CPU_RD;
    logic [7:0]  CPU_WDATA;
    logic [7:0]  CPU_RDATA;
    logic        CPU_RVALID;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    // Reference model: latched byte plus count of reads since the latch.
    int         nes_src[8] = '{8, 0, 2, 3, 4, 5, 6, 7};
    logic [11:0] m_btn_prev[2];
    logic [7:0]  m_lat[2];
    int          m_cnt[2];
    logic        m_strobe;
    int          m_edges;

    nes_joypad_regs #(.TURBO_DIV(TurboDiv)) dut (
        .CLOCK     (CLOCK),
        .RESET_N   (RESET_N),
        .BUTTONS1  (BUTTONS1),
        .BUTTONS2  (BUTTONS2),
        .CPU_ADDR  (CPU_ADDR),
        .CPU_WR    (CPU_WR),
        .CPU_RD    (CPU_RD),
        .CPU_WDATA (CPU_WDATA),
        .CPU_RDATA (CPU_RDATA),
        .CPU_RVALID(CPU_RVALID)
    );

    always #5 CLOCK = ~CLOCK;

    function automatic logic m_phase();
`ifdef JOYPAD_TURBO_EN
        return ((m_edges / TurboDiv) % 2) == 1;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [7:0] nes_view(input logic [11:0] s, input logic ph);
        logic [7:0] v;
        for (int i = 0; i < 8; i++) v[i] = s[nes_src[i]];
        v[0] = v[0] | (s[9] & ph);
        v[1] = v[1] | (s[1] & ph);
        return v;
    endfunction

    task automatic model_reset();
        m_strobe = 1'b0;
        m_edges  = 0;
        for (int p = 0; p < 2; p++) begin
            m_btn_prev[p] = '0;
            m_lat[p]      = 8'hFF;
            m_cnt[p]      = 8;
        end
        exp_q.delete();
    endtask

    // One bus cycle, entered and left at the falling edge. force_exp < 0 uses the model.
    task automatic step(input logic rd, input logic wr, input logic [15:0] addr,
                        input logic [7:0] wd, input int force_exp);
        logic [7:0] e, v;
        logic       ph, ld, nstb;
        int         p;
        CPU_RD = rd; CPU_WR = wr; CPU_ADDR = addr; CPU_WDATA = wd;
        @(posedge CLOCK);
        ph = m_phase();
        p  = (addr == 16'h4017) ? 1 : 0;
        if (rd && (addr == 16'h4016 || addr == 16'h4017)) begin
            if (m_strobe) begin
                v = nes_view(m_btn_prev[p], ph);
                e = 8'h40 | {7'b0, v[0]};
            end else begin
                e = 8'h40 | {7'b0, (m_cnt[p] < 8) ? m_lat[p][m_cnt[p]] : 1'b1};
                m_cnt[p]++;
            end
            if (force_exp >= 0) e = force_exp[7:0];
            exp_q.push_back(e);
        end
        nstb = (wr && addr == 16'h4016) ? wd[0] : m_strobe;
        ld   = m_strobe || (wr && addr == 16'h4016 && wd[0]);
        if (ld) begin
            for (int q = 0; q < 2; q++) begin
                m_lat[q] = nes_view(m_btn_prev[q], ph);
                m_cnt[q] = 0;
            end
        end
        m_strobe      = nstb;
        m_btn_prev[0] = BUTTONS1;
        m_btn_prev[1] = BUTTONS2;
        m_edges++;
        @(negedge CLOCK);
        CPU_RD = 1'b0; CPU_WR = 1'b0;
    endtask

    task automatic check_reset_outputs(input string name);
        checks++;
        if (CPU_RDATA !== 8'h00 || CPU_RVALID !== 1'b0) begin
            errors++;
            $display("FAIL %s rdata=%h rvalid=%b required rdata=00 rvalid=0",
                     name, CPU_RDATA, CPU_RVALID);
        end
    endtask

    // Monitor: every RVALID pulse must match the next queued expectation.
    always @(negedge CLOCK) begin
        if (CPU_RVALID === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rvalid_unexpected rdata=%h required=no_read", CPU_RDATA);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (CPU_RDATA !== e) begin
                    errors++;
                    $display("FAIL read_data rdata=%h required=%h", CPU_RDATA, e);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout reached without finishing");
        $fatal(1, "timeout");
    end

    initial begin
        RESET_N = 1'b0;
        BUTTONS1 = '0; BUTTONS2 = '0;
        CPU_ADDR = '0; CPU_WR = 1'b0; CPU_RD = 1'b0; CPU_WDATA = '0;
        model_reset();
        repeat (3) @(negedge CLOCK);
        check_reset_outputs("reset_values");
        RESET_N = 1'b1;

        // Reset state: no latch ever happened, reads give all ones.
        for (int i = 0; i < 3; i++) step(1, 0, 16'h4016, 8'h00, 8'h41);

        // Latch A+B and read past the end of the byte.
        BUTTONS1 = 12'h101;
        step(0, 0, 16'h0000, 8'h00, -1);
        step(0, 1, 16'h4016, 8'h01, -1);
        step(0, 1, 16'h4016, 8'h00, -1);
        for (int i = 0; i < 10; i++)
            step(1, 0, 16'h4016, 8'h00, (i < 2 || i >= 8) ? 8'h41 : 8'h40);

        // Reset in the middle of a read sequence: the pending read is dropped.
        step(1, 0, 16'h4016, 8'h00, -1);
        CPU_RD = 1'b1; CPU_ADDR = 16'h4016;
        @(posedge CLOCK);
        #1 RESET_N = 1'b0; CPU_RD = 1'b0;
        @(negedge CLOCK);
        check_reset_outputs("reset_mid_read");
        model_reset();
        RESET_N = 1'b1;
        for (int i = 0; i < 3; i++) step(1, 0, 16'h4016, 8'h00, 8'h41);

        // Strobe held: reads return live A without shifting.
        BUTTONS1 = 12'h100;
        step(0, 0, 16'h0000, 8'h00, -1);
        step(0, 1, 16'h4016, 8'h01, -1);
        for (int i = 0; i < 3; i++) step(1, 0, 16'h4016, 8'h00, 8'h41);
        BUTTONS1 = 12'h000;
        step(0, 0, 16'h0000, 8'h00, -1);
        step(1, 0, 16'h4016, 8'h00, 8'h40);
        step(0, 1, 16'h4016, 8'h00, -1);

        // Player 2 Right only; interleaved player 1 reads must not disturb it.
        BUTTONS2 = 12'h080;
        step(0, 0, 16'h0000, 8'h00, -1);
        step(0, 1, 16'h4016, 8'h01, -1);
        step(0, 1, 16'h4016, 8'h00, -1);
        for (int i = 0; i < 8; i++) begin
            step(1, 0, 16'h4017, 8'h00, (i == 7) ? 8'h41 : 8'h40);
            step(1, 0, 16'h4016, 8'h00, -1);
        end

        // Writes to 4017 and reads of other addresses do nothing.
        step(0, 1, 16'h4017, 8'h01, -1);
        step(1, 0, 16'h4000, 8'h00, -1);
        step(1, 0, 16'h4018, 8'h00, -1);
        step(1, 0, 16'h4017, 8'h00, 8'h41);

        // Simultaneous read and strobe write: read sees pre-write state, then reload.
        BUTTONS1 = 12'h100;
        step(0, 0, 16'h0000, 8'h00, -1);
        step(0, 1, 16'h4016, 8'h01, -1);
        step(0, 1, 16'h4016, 8'h00, -1);
        step(1, 1, 16'h4016, 8'h01, 8'h41);
        step(0, 1, 16'h4016, 8'h00, -1);
        step(1, 0, 16'h4016, 8'h00, 8'h41);
        step(1, 0, 16'h4016, 8'h00, 8'h40);

`ifdef JOYPAD_TURBO_EN
        // Turbo X: A follows the turbo phase while strobe is held.
        BUTTONS1 = 12'h200;
        step(0, 0, 16'h0000, 8'h00, -1);
        step(0, 1, 16'h4016, 8'h01, -1);
        for (int i = 0; i < 16; i++) step(1, 0, 16'h4016, 8'h00, -1);
        step(0, 1, 16'h4016, 8'h00, -1);
`endif

        // Randomized traffic against the model.
        for (int n = 0; n < 500; n++) begin
            logic [15:0] a;
            int          sel;
            if ($urandom_range(0, 7) == 0) BUTTONS1 = 12'($urandom);
            if ($urandom_range(0, 7) == 0) BUTTONS2 = 12'($urandom);
            sel = $urandom_range(0, 9);
            a = (sel < 4) ? 16'h4016 : (sel < 7) ? 16'h4017 : (sel < 8) ? 16'h4015 :
                16'($urandom);
            step($urandom_range(0, 2) != 0, $urandom_range(0, 5) == 0, a,
                 8'($urandom), -1);
        end

        repeat (3) @(negedge CLOCK);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain pending=%0d required=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
